// File: rtl/ahb2apb_bridge_param.sv
// AHB-Lite to APB bridge decoding single transfers onto NUM_SLV APB slaves.
// Define BRIDGE_TIMEOUT_EN to bound ACCESS at TIMEOUT_CYC cycles with an ERROR response.
module ahb2apb_bridge_param #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                REGION_LOG2 = 16,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic                      Hclk,
  input  logic                      Hreset,
  input  logic                      Hwrite,
  input  logic                      Hreadyin,
  input  logic [1:0]                Htrans,
  input  logic [ADDR_W-1:0]         Haddr,
  input  logic [DATA_W-1:0]         Hwdata,
  output logic                      Hready_out,
  output logic [1:0]                Hresp,
  output logic [DATA_W-1:0]         Hrdata,
  output logic [NUM_SLV-1:0]        Pselx,
  output logic                      Penable,
  output logic                      Pwrite,
  output logic [ADDR_W-1:0]         Paddr,
  output logic [DATA_W-1:0]         Pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] Prdata,
  input  logic [NUM_SLV-1:0]        Pready,
  input  logic [NUM_SLV-1:0]        Pslverr
);
  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("ahb2apb_bridge_param: unsupported configuration");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WLATCH, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [ADDR_W-1:0]  offset;
  logic [ADDR_W-1:0]  region;
  logic [IDX_W-1:0]   dec_idx;
  logic               miss;
  logic               accept;
  logic               sel_ready;
  logic               sel_err;
  logic [DATA_W-1:0]  sel_rdata;
  logic               timeout;

  function automatic logic [NUM_SLV-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  always_comb begin
    offset    = Haddr - BASE_ADDR;
    region    = offset >> REGION_LOG2;
    miss      = (Haddr < BASE_ADDR) || (region >= ADDR_W'(NUM_SLV));
    dec_idx   = region[IDX_W-1:0];
    accept    = (Htrans == 2'b10 || Htrans == 2'b11) && Hreadyin && Hready_out;
    sel_ready = Pready[idx];
    sel_err   = Pslverr[idx];
    sel_rdata = Prdata[idx*DATA_W +: DATA_W];
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] acc_cnt;

  // Counter rests at zero outside ACCESS so every ACCESS phase starts fresh.
  always_ff @(posedge Hclk) begin
    if (Hreset || state != S_ACCESS) acc_cnt <= '0;
    else                             acc_cnt <= acc_cnt + 1'b1;
  end

  assign timeout = (acc_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state      <= S_IDLE;
      idx        <= '0;
      Hready_out <= 1'b1;
      Hresp      <= 2'b00;
      Hrdata     <= '0;
      Pselx      <= '0;
      Penable    <= 1'b0;
      Pwrite     <= 1'b0;
      Paddr      <= '0;
      Pwdata     <= '0;
    end else if ((state == S_IDLE || state == S_ERR2) && accept) begin
      // ERR2 doubles as a completion cycle, so it accepts like IDLE.
      Hready_out <= 1'b0;
      if (miss) begin
        state <= S_ERR1;
        Hresp <= 2'b01;
      end else begin
        Hresp  <= 2'b00;
        idx    <= dec_idx;
        Paddr  <= Haddr;
        Pwrite <= Hwrite;
        if (Hwrite) begin
          state <= S_WLATCH;
        end else begin
          state <= S_SETUP;
          Pselx <= onehot(dec_idx);
        end
      end
    end else begin
      case (state)
        S_WLATCH: begin
          Pwdata <= Hwdata;
          Pselx  <= onehot(idx);
          state  <= S_SETUP;
        end
        S_SETUP: begin
          Penable <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (sel_ready) begin
            Pselx   <= '0;
            Penable <= 1'b0;
            if (sel_err) begin
              state <= S_ERR1;
              Hresp <= 2'b01;
            end else begin
              state      <= S_IDLE;
              Hready_out <= 1'b1;
              if (!Pwrite) Hrdata <= sel_rdata;
            end
          end else if (timeout) begin
            Pselx   <= '0;
            Penable <= 1'b0;
            state   <= S_ERR1;
            Hresp   <= 2'b01;
          end
        end
        S_ERR1: begin
          state      <= S_ERR2;
          Hready_out <= 1'b1;
        end
        S_ERR2: begin
          state <= S_IDLE;
          Hresp <= 2'b00;
        end
        default: begin
          state      <= S_IDLE;
          Hready_out <= 1'b1;
          Hresp      <= 2'b00;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb2apb_bridge_param.sv
// Randomized bench for ahb2apb_bridge_param against a cycle-window transaction model.
module tb_ahb2apb_bridge_param;
  localparam int          ADDR_W      = 32;
  localparam int          DATA_W      = 32;
  localparam int          NUM_SLV     = 4;
  localparam int          REGION_LOG2 = 16;
  localparam int          TIMEOUT_CYC = 16;
  localparam logic [31:0] BASE_ADDR   = 32'h8000_0000;

  logic                      Hclk = 1'b0;
  logic                      Hreset;
  logic                      Hwrite;
  logic                      Hreadyin;
  logic [1:0]                Htrans;
  logic [ADDR_W-1:0]         Haddr;
  logic [DATA_W-1:0]         Hwdata;
  logic                      Hready_out;
  logic [1:0]                Hresp;
  logic [DATA_W-1:0]         Hrdata;
  logic [NUM_SLV-1:0]        Pselx;
  logic                      Penable;
  logic                      Pwrite;
  logic [ADDR_W-1:0]         Paddr;
  logic [DATA_W-1:0]         Pwdata;
  logic [NUM_SLV*DATA_W-1:0] Prdata;
  logic [NUM_SLV-1:0]        Pready;
  logic [NUM_SLV-1:0]        Pslverr;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [31:0] exp_hrdata;

  always #5 Hclk = ~Hclk;

  ahb2apb_bridge_param #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .BASE_ADDR(BASE_ADDR),
    .REGION_LOG2(REGION_LOG2), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Hready_out(Hready_out),
    .Hresp(Hresp), .Hrdata(Hrdata), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata),
    .Pready(Pready), .Pslverr(Pslverr)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_hready"}, Hready_out, 1'b1);
    check_val({tag, "_hresp"}, Hresp, 2'b00);
    check_val({tag, "_hrdata"}, Hrdata, 32'h0);
    check_val({tag, "_psel"}, Pselx, 4'b0000);
    check_val({tag, "_penable"}, Penable, 1'b0);
    check_val({tag, "_pwrite"}, Pwrite, 1'b0);
    check_val({tag, "_paddr"}, Paddr, 32'h0);
    check_val({tag, "_pwdata"}, Pwdata, 32'h0);
  endtask

  // Unselected slaves babble on every APB input; only the selected one follows the model.
  task automatic drive_slaves(input int sidx, input logic rdy, input logic err, input logic [31:0] rdat);
    Prdata = {$urandom, $urandom, $urandom, $urandom};
    Pready = 4'($urandom);
    Pslverr = 4'($urandom);
    Prdata[sidx*32 +: 32] = rdat;
    Pready[sidx] = rdy;
    Pslverr[sidx] = err;
  endtask

  // Called at the negedge of a cycle where the bridge shows Hready_out=1; returns at the
  // negedge of the transfer's completion cycle so the next call can be back-to-back.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input int waits, input logic serr, input logic [31:0] rdat);
    logic [31:0] off;
    bit          hit;
    bit          err;
    int          sidx, s_t, a_end, l_end;
    logic [3:0]  sel;
    off   = addr - BASE_ADDR;
    hit   = (addr >= BASE_ADDR) && ((off >> REGION_LOG2) < NUM_SLV);
    sidx  = hit ? int'(off >> REGION_LOG2) : 0;
    sel   = hit ? 4'(1 << sidx) : 4'b0000;
    s_t   = wr ? 2 : 1;
    a_end = s_t + 1 + waits;
    err   = !hit || serr;
    l_end = !hit ? 2 : (serr ? a_end + 2 : a_end + 1);
    Htrans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
    Haddr = addr;
    Hwrite = wr;
    Hreadyin = 1'b1;
    drive_slaves(sidx, 1'b0, serr, rdat);
    @(posedge Hclk);
    #1;
    Htrans = 2'b00;
    Hwdata = wdata;
    Haddr = $urandom;
    Hwrite = 1'($urandom);
    for (int t = 1; t <= l_end; t++) begin
      @(negedge Hclk);
      if (t == l_end && hit && !serr && !wr) exp_hrdata = rdat;
      check_val($sformatf("hready_t%0d", t), Hready_out, t == l_end);
      check_val($sformatf("hresp_t%0d", t), Hresp, (err && t >= l_end - 1) ? 2'b01 : 2'b00);
      check_val($sformatf("psel_t%0d", t), Pselx, (hit && t >= s_t && t <= a_end) ? sel : 4'b0000);
      check_val($sformatf("penable_t%0d", t), Penable, hit && t > s_t && t <= a_end);
      check_val($sformatf("hrdata_t%0d", t), Hrdata, exp_hrdata);
      if (hit && t >= s_t && t <= a_end) begin
        check_val($sformatf("paddr_t%0d", t), Paddr, addr);
        check_val($sformatf("pwrite_t%0d", t), Pwrite, wr);
        if (wr) check_val($sformatf("pwdata_t%0d", t), Pwdata, wdata);
      end
      drive_slaves(sidx, hit && t == a_end, serr, rdat);
    end
  endtask

  // Idle cycles carrying transfers that must be ignored (IDLE/BUSY, or Hreadyin low).
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) != 0) begin
        Htrans = 2'($urandom_range(0, 1));
        Hreadyin = 1'($urandom);
      end else begin
        Htrans = 2'($urandom_range(2, 3));
        Hreadyin = 1'b0;
      end
      Haddr = BASE_ADDR + 32'($urandom_range(0, 3) << 16);
      Hwrite = 1'($urandom);
      @(negedge Hclk);
      check_val("idle_hready", Hready_out, 1'b1);
      check_val("idle_hresp", Hresp, 2'b00);
      check_val("idle_psel", Pselx, 4'b0000);
      check_val("idle_penable", Penable, 1'b0);
    end
  endtask

  task automatic reset_bridge();
    Hreset = 1'b1;
    Htrans = 2'b00;
    @(negedge Hclk);
    check_reset_outputs("reset");
    Hreset = 1'b0;
    exp_hrdata = 32'h0;
  endtask

  initial begin
    int          r;
    logic [31:0] a;
    Hreset = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00;
    Haddr = '0; Hwdata = '0; Prdata = '0; Pready = '0; Pslverr = '0;
    exp_hrdata = 32'h0;
    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    check_reset_outputs("por");
    Hreset = 1'b0;

    // Directed cases from the plan.
    xfer(32'h8001_0004, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    idle_cycles(2);
    xfer(32'h8000_0010, 1'b1, 32'hA5A5_0001, 2, 1'b0, 32'h1234_5678);
    idle_cycles(1);
    xfer(32'h7FFF_FFFC, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_0BAD);
    xfer(32'h8004_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_0BAD);
    idle_cycles(1);
    xfer(32'h8002_0008, 1'b1, 32'h5555_AAAA, 0, 1'b1, 32'h0);
    xfer(32'h8003_0100, 1'b0, 32'h0, 1, 1'b0, 32'hCAFE_F00D);
    xfer(32'h8001_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0000_1111);
    xfer(32'h8002_0020, 1'b0, 32'h0, 0, 1'b1, 32'hFFFF_FFFF);
    idle_cycles(1);

    // Reset while an APB read sits in ACCESS waiting on Pready.
    Htrans = 2'b10; Haddr = 32'h8003_0000; Hwrite = 1'b0; Hreadyin = 1'b1;
    drive_slaves(3, 1'b0, 1'b0, 32'h7777_7777);
    @(posedge Hclk);
    #1 Htrans = 2'b00;
    for (int t = 1; t <= 3; t++) begin
      @(negedge Hclk);
      drive_slaves(3, 1'b0, 1'b0, 32'h7777_7777);
    end
    check_val("rst_mid_penable_before", Penable, 1'b1);
    reset_bridge();
    idle_cycles(1);

    // ACCESS with the selected slave stuck not-ready.
    Htrans = 2'b10; Haddr = 32'h8003_0040; Hwrite = 1'b0; Hreadyin = 1'b1;
    drive_slaves(3, 1'b0, 1'b0, 32'h3333_3333);
    @(posedge Hclk);
    #1 Htrans = 2'b00;
`ifdef BRIDGE_TIMEOUT_EN
    for (int t = 1; t <= TIMEOUT_CYC + 3; t++) begin
      @(negedge Hclk);
      if (t == TIMEOUT_CYC + 1) check_val("to_last_access", Penable, 1'b1);
      if (t == TIMEOUT_CYC + 2) begin
        check_val("to_err1_hresp", Hresp, 2'b01);
        check_val("to_err1_hready", Hready_out, 1'b0);
        check_val("to_err1_psel", Pselx, 4'b0000);
        check_val("to_err1_penable", Penable, 1'b0);
      end
      if (t == TIMEOUT_CYC + 3) begin
        check_val("to_err2_hresp", Hresp, 2'b01);
        check_val("to_err2_hready", Hready_out, 1'b1);
        check_val("to_hrdata_kept", Hrdata, exp_hrdata);
      end
      drive_slaves(3, 1'b0, 1'b0, 32'h3333_3333);
    end
    idle_cycles(1);
`else
    for (int t = 1; t <= 101; t++) begin
      @(negedge Hclk);
      drive_slaves(3, 1'b0, 1'b0, 32'h3333_3333);
    end
    check_val("stuck_penable", Penable, 1'b1);
    check_val("stuck_psel", Pselx, 4'b1000);
    check_val("stuck_hready", Hready_out, 1'b0);
    reset_bridge();
    idle_cycles(1);
`endif

    // Random traffic with random gaps (zero gap = back-to-back).
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = BASE_ADDR + 32'($urandom_range(0, 3) << 16) + ($urandom & 32'h0000_FFFC);
      else if (r == 8) a = $urandom & 32'h7FFF_FFFC;
      else             a = BASE_ADDR + 32'h0004_0000 + ($urandom & 32'h0FFF_FFFC);
      xfer(a, 1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
